vector_compare_unit: RTL and testbench
======================================

Name: vector_compare_unit

Overview:
Multi-lane, multi-beat vector comparator and the parametrised successor of the single-word equality checker. One operation compares two vectors of LANES*BEATS elements, streamed LANES elements per beat under a valid/ready handshake. It produces a per-element result mask and a match count for the vector datapath's predicate/mask register file. Comparison mode is selectable per operation: equality, inequality, signed or unsigned ordering.

Parameters:
WIDTH, 32, element width in bits
LANES, 4, elements compared per beat
BEATS, 4, beats per operation; vector length VLEN = LANES*BEATS

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  begin operation; honoured only in IDLE
MODE  in  3  compare mode, sampled on accepted START
IN_VALID  in  1  beat data valid
IN_READY  out  1  unit accepts a beat
DATA_IN_1  in  WIDTH*LANES  operand A; lane i at [i*WIDTH +: WIDTH]
DATA_IN_2  in  WIDTH*LANES  operand B, same packing
OUT_VALID  out  1  result available
OUT_READY  in  1  consumer takes the result
MASK  out  VLEN  per-element result; element e = beat*LANES + lane
MATCH_COUNT  out  $clog2(VLEN+1)  number of 1 bits in MASK
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous, RST_N=0: state IDLE; IN_READY, OUT_VALID, BUSY, MASK and MATCH_COUNT all 0; beat counter 0; latched mode 0.
- MODE encoding:
  - 000 EQ; 001 NE
  - 010 LT unsigned; 011 GE unsigned
  - 100 LT signed, two's complement; 101 GE signed
  - 110/111 reserved: every element result is 0.
- FSM IDLE:
  - START=1 → ACCEPT on the next edge.
  - On that edge: latch MODE, clear MASK and MATCH_COUNT, clear the beat counter.
- FSM ACCEPT:
  - IN_READY=1 combinationally.
  - On IN_VALID&IN_READY: evaluate all LANES comparisons and write them to MASK[beat*LANES +: LANES].
  - On the same edge, add the popcount of the beat to MATCH_COUNT and increment the beat counter.
  - Cycles with IN_VALID=0 are stalls; no state changes.
  - After the handshake of beat BEATS-1 → DONE.
- FSM DONE:
  - OUT_VALID=1 and IN_READY=0.
  - MASK and MATCH_COUNT are held stable until OUT_VALID&OUT_READY.
  - On that handshake → IDLE on the next edge. MASK and MATCH_COUNT keep their values in IDLE until the next START.
- Latency: OUT_VALID rises on the edge that accepts the final beat, i.e. visible one cycle after the last beat is presented. Minimum operation time is 1 (START) + BEATS + 1 (output) cycles.
- START outside IDLE (ACCEPT or DONE) is ignored, including in the DONE cycle where the output handshake completes. START is accepted no earlier than the following IDLE cycle.
- MODE changes after START have no effect until the next operation.
- Reset asserted mid-operation aborts immediately to reset values. Partial results are discarded and no OUT_VALID is produced.
- MATCH_COUNT never wraps: its width holds VLEN exactly.
- The beat counter uses $clog2(BEATS) bits, minimum 1. BEATS=1 must work: one beat takes ACCEPT directly to DONE.

Optional Feature:
- Macro VCMP_FIRST_MATCH_EN.
- Defined: adds outputs FIRST_FOUND (1 bit) and FIRST_IDX ($clog2(VLEN) bits, minimum 1).
  - Both are registered and updated on each accepted beat.
  - FIRST_IDX holds the lowest element index whose MASK bit is 1; FIRST_FOUND=1 once any bit is set.
  - Both clear to 0 on reset and on accepted START, and are valid while OUT_VALID=1.
- Not defined: the ports do not exist and no related logic is present.

Test Plan:
All scenarios use WIDTH=32, LANES=4, BEATS=4.
- Reset: hold RST_N=0 mid-cycle with stimulus active → IN_READY=0, OUT_VALID=0, BUSY=0, MASK=16'h0000, MATCH_COUNT=0, asynchronously.
- EQ: MODE=000, all beats all lanes 256 vs 256 → MASK=16'hFFFF, MATCH_COUNT=16, OUT_VALID one cycle after beat 3. Repeat with lane 2 of beat 1 = 0 vs 256 → MASK=16'hFFBF, MATCH_COUNT=15.
- Signedness: every lane 32'hFFFFFFFF vs 32'd4 → MODE=100 gives MASK=16'hFFFF, count 16. MODE=010 gives MASK=16'h0000, count 0. MODE=110 gives 16'h0000.
- Backpressure: IN_VALID low for 2 cycles between each beat, OUT_READY low for 5 cycles; pulse START during DONE → OUT_VALID held, MASK unchanged, START ignored, BUSY=1 until the handshake.
- Abort: assert RST_N=0 after beat 2 of an NE op with 100 vs 4 → all outputs 0. Next EQ op with 0 vs 0 yields MASK=16'hFFFF, count 16, with no leftover bits.
- VCMP_FIRST_MATCH_EN: EQ op with only element 9 equal → MASK=16'h0200, MATCH_COUNT=1, FIRST_FOUND=1, FIRST_IDX=9. An all-unequal op → FIRST_FOUND=0, FIRST_IDX=0.

Source files
------------

// File: rtl/vector_compare_unit.sv
// Multi-lane, multi-beat vector comparator producing a per-element mask and match count.
// Optional first-match tracking (FIRST_FOUND/FIRST_IDX) is enabled by defining VCMP_FIRST_MATCH_EN.

module vcu_lane #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    output logic             res
);
    logic eq, lt_u, lt_s;

    always_comb begin
        eq   = (a == b);
        lt_u = (a < b);
        lt_s = ($signed(a) < $signed(b));
        case (mode)
            3'b000:  res = eq;
            3'b001:  res = !eq;
            3'b010:  res = lt_u;
            3'b011:  res = !lt_u;
            3'b100:  res = lt_s;
            3'b101:  res = !lt_s;
            default: res = 1'b0;
        endcase
    end
endmodule

module vector_compare_unit #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int BEATS = 4,
    localparam int VLEN   = LANES * BEATS,
    localparam int CNT_W  = $clog2(VLEN + 1),
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int IDX_W  = (VLEN > 1) ? $clog2(VLEN) : 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   START,
    input  logic [2:0]             MODE,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [WIDTH*LANES-1:0] DATA_IN_1,
    input  logic [WIDTH*LANES-1:0] DATA_IN_2,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [VLEN-1:0]        MASK,
    output logic [CNT_W-1:0]       MATCH_COUNT,
`ifdef VCMP_FIRST_MATCH_EN
    output logic                   FIRST_FOUND,
    output logic [IDX_W-1:0]       FIRST_IDX,
`endif
    output logic                   BUSY
);
    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        mode_q, mode_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [VLEN-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic [LANES-1:0]  lane_res;
    logic [CNT_W-1:0]  beat_pop;
    logic              beat_fire;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            vcu_lane #(.WIDTH(WIDTH)) u_lane (
                .a    (DATA_IN_1[gi*WIDTH +: WIDTH]),
                .b    (DATA_IN_2[gi*WIDTH +: WIDTH]),
                .mode (mode_q),
                .res  (lane_res[gi])
            );
        end
    endgenerate

    always_comb begin
        beat_pop = '0;
        for (int l = 0; l < LANES; l++)
            beat_pop = beat_pop + CNT_W'(lane_res[l]);
    end

    assign beat_fire = IN_VALID && (state_q == S_ACCEPT);

`ifdef VCMP_FIRST_MATCH_EN
    logic             first_found_q, first_found_d;
    logic [IDX_W-1:0] first_idx_q, first_idx_d;
    logic [IDX_W-1:0] beat_low_idx;

    // Scan high to low so the lowest set lane of this beat wins.
    always_comb begin
        beat_low_idx = '0;
        for (int l = LANES - 1; l >= 0; l--)
            if (lane_res[l])
                beat_low_idx = IDX_W'(int'(beat_q) * LANES + l);
    end
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        beat_d  = beat_q;
        mask_d  = mask_q;
        count_d = count_q;
`ifdef VCMP_FIRST_MATCH_EN
        first_found_d = first_found_q;
        first_idx_d   = first_idx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_ACCEPT;
                    mode_d  = MODE;
                    beat_d  = '0;
                    mask_d  = '0;
                    count_d = '0;
`ifdef VCMP_FIRST_MATCH_EN
                    first_found_d = 1'b0;
                    first_idx_d   = '0;
`endif
                end
            end
            S_ACCEPT: begin
                if (beat_fire) begin
                    for (int b = 0; b < BEATS; b++)
                        if (beat_q == BEAT_W'(b))
                            mask_d[b*LANES +: LANES] = lane_res;
                    count_d = count_q + beat_pop;
`ifdef VCMP_FIRST_MATCH_EN
                    if (!first_found_q && (|lane_res)) begin
                        first_found_d = 1'b1;
                        first_idx_d   = beat_low_idx;
                    end
`endif
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_d = S_DONE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (OUT_READY)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            beat_q      <= '0;
            mask_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            beat_q      <= beat_d;
            mask_q      <= mask_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef VCMP_FIRST_MATCH_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            first_found_q <= 1'b0;
            first_idx_q   <= '0;
        end else begin
            first_found_q <= first_found_d;
            first_idx_q   <= first_idx_d;
        end
    end

    assign FIRST_FOUND = first_found_q;
    assign FIRST_IDX   = first_idx_q;
`endif

    assign IN_READY    = (state_q == S_ACCEPT);
    assign OUT_VALID   = out_valid_q;
    assign BUSY        = busy_q;
    assign MASK        = mask_q;
    assign MATCH_COUNT = count_q;
endmodule

// File: tb/tb_vector_compare_unit.sv
// Directed, table-driven bench for vector_compare_unit (WIDTH=32, LANES=4, BEATS=4).
module tb_vector_compare_unit;
    localparam int WIDTH = 32;
    localparam int LANES = 4;
    localparam int BEATS = 4;
    localparam int VLEN  = 16;

    logic                   CLK = 1'b0;
    logic                   RST_N;
    logic                   START;
    logic [2:0]             MODE;
    logic                   IN_VALID;
    logic                   IN_READY;
    logic [WIDTH*LANES-1:0] DATA_IN_1;
    logic [WIDTH*LANES-1:0] DATA_IN_2;
    logic                   OUT_VALID;
    logic                   OUT_READY;
    logic [VLEN-1:0]        MASK;
    logic [4:0]             MATCH_COUNT;
    logic                   BUSY;
`ifdef VCMP_FIRST_MATCH_EN
    logic                   FIRST_FOUND;
    logic [3:0]             FIRST_IDX;
`endif

    vector_compare_unit #(.WIDTH(WIDTH), .LANES(LANES), .BEATS(BEATS)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .START       (START),
        .MODE        (MODE),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .DATA_IN_1   (DATA_IN_1),
        .DATA_IN_2   (DATA_IN_2),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .MASK        (MASK),
        .MATCH_COUNT (MATCH_COUNT),
`ifdef VCMP_FIRST_MATCH_EN
        .FIRST_FOUND (FIRST_FOUND),
        .FIRST_IDX   (FIRST_IDX),
`endif
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]             mode;
        logic [VLEN-1:0][31:0]  a;
        logic [VLEN-1:0][31:0]  b;
        logic [VLEN-1:0]        mask;
        int                     cnt;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] m, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [VLEN-1:0] msk, input int c);
        vec_t v;
        v.mode = m;
        for (int i = 0; i < VLEN; i++) begin
            v.a[i] = av;
            v.b[i] = bv;
        end
        v.mask = msk;
        v.cnt  = c;
        return v;
    endfunction

    task automatic drive_beat(input vec_t r, input int bt);
        for (int l = 0; l < LANES; l++) begin
            DATA_IN_1[l*WIDTH +: WIDTH] = r.a[bt*LANES + l];
            DATA_IN_2[l*WIDTH +: WIDTH] = r.b[bt*LANES + l];
        end
    endtask

    // One full operation; inputs change on negedges, outputs are checked on negedges.
    task automatic run_op(input string nm, input vec_t r, input int gap, input int hold, input logic start_in_done);
        @(negedge CLK);
        START = 1'b1;
        MODE  = r.mode;
        @(negedge CLK);
        START = 1'b0;
        MODE  = r.mode ^ 3'b111;
        chk({nm, ".in_ready"}, 64'(IN_READY), 64'd1);
        chk({nm, ".busy"}, 64'(BUSY), 64'd1);
        chk({nm, ".mask_clr"}, 64'(MASK), 64'd0);
        chk({nm, ".cnt_clr"}, 64'(MATCH_COUNT), 64'd0);
        for (int bt = 0; bt < BEATS; bt++) begin
            for (int g = 0; g < gap; g++) begin
                IN_VALID = 1'b0;
                drive_beat(r, (bt + 1) % BEATS);
                @(negedge CLK);
                chk({nm, ".stall_ready"}, 64'(IN_READY), 64'd1);
            end
            IN_VALID = 1'b1;
            drive_beat(r, bt);
            if (bt == BEATS - 1) begin
                #1;
                chk({nm, ".ov_early"}, 64'(OUT_VALID), 64'd0);
            end
            @(negedge CLK);
        end
        IN_VALID = 1'b0;
        chk({nm, ".out_valid"}, 64'(OUT_VALID), 64'd1);
        chk({nm, ".in_ready_done"}, 64'(IN_READY), 64'd0);
        chk({nm, ".mask"}, 64'(MASK), 64'(r.mask));
        chk({nm, ".count"}, 64'(MATCH_COUNT), 64'(r.cnt));
`ifdef VCMP_FIRST_MATCH_EN
        begin
            logic [3:0] fi;
            fi = '0;
            for (int i = VLEN - 1; i >= 0; i--) if (r.mask[i]) fi = 4'(i);
            chk({nm, ".first_found"}, 64'(FIRST_FOUND), 64'(r.mask != '0));
            chk({nm, ".first_idx"}, 64'(FIRST_IDX), 64'(fi));
        end
`endif
        for (int h = 0; h < hold; h++) begin
            START = start_in_done;
            @(negedge CLK);
            START = 1'b0;
            chk({nm, ".hold_ov"}, 64'(OUT_VALID), 64'd1);
            chk({nm, ".hold_busy"}, 64'(BUSY), 64'd1);
            chk({nm, ".hold_mask"}, 64'(MASK), 64'(r.mask));
        end
        OUT_READY = 1'b1;
        START     = start_in_done;
        @(negedge CLK);
        OUT_READY = 1'b0;
        START     = 1'b0;
        chk({nm, ".ov_drop"}, 64'(OUT_VALID), 64'd0);
        chk({nm, ".idle_busy"}, 64'(BUSY), 64'd0);
        chk({nm, ".idle_mask"}, 64'(MASK), 64'(r.mask));
        @(negedge CLK);
        chk({nm, ".idle_ready"}, 64'(IN_READY), 64'd0);
        chk({nm, ".idle_busy2"}, 64'(BUSY), 64'd0);
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = mkv(3'b000, 32'd256, 32'd256, 16'hFFFF, 16);
        tbl[1]  = mkv(3'b000, 32'd256, 32'd256, 16'hFFBF, 15);
        tbl[1].a[6] = 32'd0;
        tbl[2]  = mkv(3'b100, 32'hFFFFFFFF, 32'd4, 16'hFFFF, 16);
        tbl[3]  = mkv(3'b010, 32'hFFFFFFFF, 32'd4, 16'h0000, 0);
        tbl[4]  = mkv(3'b110, 32'hFFFFFFFF, 32'd4, 16'h0000, 0);
        tbl[5]  = mkv(3'b011, 32'hFFFFFFFF, 32'd4, 16'hFFFF, 16);
        tbl[6]  = mkv(3'b101, 32'hFFFFFFFF, 32'd4, 16'h0000, 0);
        tbl[7]  = mkv(3'b001, 32'd100, 32'd100, 16'h8000, 1);
        tbl[7].a[15] = 32'd7;
        tbl[8]  = mkv(3'b010, 32'd0, 32'd8, 16'h00FF, 8);
        for (int i = 0; i < VLEN; i++) tbl[8].a[i] = 32'(i);
        tbl[9]  = mkv(3'b000, 32'd1, 32'd2, 16'h0200, 1);
        tbl[9].b[9] = 32'd1;
        tbl[10] = mkv(3'b000, 32'd5, 32'd6, 16'h0000, 0);

        // Reset held with stimulus active.
        RST_N = 1'b0; START = 1'b1; MODE = 3'b000; IN_VALID = 1'b1; OUT_READY = 1'b1;
        DATA_IN_1 = '0; DATA_IN_2 = '0;
        repeat (2) @(negedge CLK);
        chk("rst.in_ready", 64'(IN_READY), 64'd0);
        chk("rst.out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst.busy", 64'(BUSY), 64'd0);
        chk("rst.mask", 64'(MASK), 64'd0);
        chk("rst.count", 64'(MATCH_COUNT), 64'd0);
        RST_N = 1'b1; START = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;

        for (int t = 0; t < 11; t++)
            run_op($sformatf("vec%0d", t), tbl[t], 0, 0, 1'b0);

        // Backpressure: stalls between beats, delayed consumer, START pulsed in DONE.
        run_op("bp", tbl[1], 2, 5, 1'b1);

        // Abort an NE op mid-way with an asynchronous reset.
        begin
            vec_t ne;
            ne = mkv(3'b001, 32'd100, 32'd4, 16'hFFFF, 16);
            @(negedge CLK);
            START = 1'b1; MODE = 3'b001;
            @(negedge CLK);
            START = 1'b0;
            for (int bt = 0; bt < 3; bt++) begin
                IN_VALID = 1'b1;
                drive_beat(ne, bt);
                @(negedge CLK);
            end
            chk("abort.partial", 64'(MASK), 64'h0FFF);
            #2 RST_N = 1'b0;
            #1;
            chk("abort.mask", 64'(MASK), 64'd0);
            chk("abort.count", 64'(MATCH_COUNT), 64'd0);
            chk("abort.busy", 64'(BUSY), 64'd0);
            chk("abort.in_ready", 64'(IN_READY), 64'd0);
            chk("abort.out_valid", 64'(OUT_VALID), 64'd0);
            @(negedge CLK);
            RST_N = 1'b1;
            IN_VALID = 1'b0;
            repeat (3) @(negedge CLK);
            chk("abort.no_ov", 64'(OUT_VALID), 64'd0);
        end
        run_op("post_abort", mkv(3'b000, 32'd0, 32'd0, 16'hFFFF, 16), 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
